// File: rtl/fsk4_pkg.sv
// fsk4_pkg: shared definitions for the 4-FSK tone detector.
//   Symbol/bin defaults, datapath widths, FSM state type and the helper that
//   maps (tone bin, sample index) onto the 16-entry cos/sin table.
package fsk4_pkg;

    localparam int SPS_DEF = 16;
    localparam int K0_DEF  = 1;
    localparam int K1_DEF  = 3;
    localparam int K2_DEF  = 5;
    localparam int K3_DEF  = 7;

    localparam int COEF_W = 16;
    localparam int ACC_W  = 40;
    localparam int E_W    = 48;
    // Accumulators are reduced by this many bits before squaring.
    localparam int SHIFT  = 16;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } fsk4_state_t;

    // The ROM always holds 16 points per period; for shorter symbols the
    // (k*n mod sps) phase is stretched onto that grid.
    function automatic logic [3:0] coef_index(input int k, input int n, input int sps);
        int idx;
        idx = ((k * n) % sps) * (16 / sps);
        return 4'(idx);
    endfunction

endpackage

// File: rtl/fsk4_tone_lut.sv
// fsk4_tone_lut: combinational cos/sin ROM, 16 points per period, Q1.14.
//   idx     : phase index, angle = 2*pi*idx/16
//   cos_val : round(16384*cos(angle))
//   sin_val : round(16384*sin(angle))
module fsk4_tone_lut
    import fsk4_pkg::*;
(
    input  logic [3:0]               idx,
    output logic signed [COEF_W-1:0] cos_val,
    output logic signed [COEF_W-1:0] sin_val
);

    function automatic logic signed [COEF_W-1:0] cos_tab(input logic [3:0] k);
        logic signed [COEF_W-1:0] v;
        case (k)
            4'd0:    v = 16'sd16384;
            4'd1:    v = 16'sd15137;
            4'd2:    v = 16'sd11585;
            4'd3:    v = 16'sd6270;
            4'd4:    v = 16'sd0;
            4'd5:    v = -16'sd6270;
            4'd6:    v = -16'sd11585;
            4'd7:    v = -16'sd15137;
            4'd8:    v = -16'sd16384;
            4'd9:    v = -16'sd15137;
            4'd10:   v = -16'sd11585;
            4'd11:   v = -16'sd6270;
            4'd12:   v = 16'sd0;
            4'd13:   v = 16'sd6270;
            4'd14:   v = 16'sd11585;
            default: v = 16'sd15137;
        endcase
        return v;
    endfunction

    // sin(theta) = cos(theta - pi/2), a quarter period is 4 table steps.
    assign cos_val = cos_tab(idx);
    assign sin_val = cos_tab(idx - 4'd4);

endmodule

// File: rtl/fsk4_tone_detector.sv
// fsk4_tone_detector: non-coherent 4-FSK detector.
//   Correlates each SPS-sample symbol of complex input against four DFT bins,
//   then reports the bin with the largest energy.
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   in_valid              : input_1/input_2 (I/Q, signed 18b) carry a sample
//   sym_sync              : with in_valid, this sample is index 0 of a symbol
//   sym_out/metric        : winning tone index and its energy
//   sym_valid             : one-cycle pulse when sym_out/metric update
//
//   state    | meaning
//   ST_IDLE  | waiting for in_valid && sym_sync, samples ignored
//   ST_ACCUM | correlating samples, n = index of next sample in symbol
module fsk4_tone_detector
    import fsk4_pkg::*;
#(
    parameter int SPS = SPS_DEF,
    parameter int K0  = K0_DEF,
    parameter int K1  = K1_DEF,
    parameter int K2  = K2_DEF,
    parameter int K3  = K3_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [17:0]   input_1,
    input  logic signed [17:0]   input_2,
    input  logic                 sym_sync,
    output logic [1:0]           sym_out,
    output logic                 sym_valid,
    output logic [E_W-1:0]       metric
);

    localparam int NW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int K_ARR [4] = '{K0, K1, K2, K3};
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    fsk4_state_t state;
    logic [NW-1:0] n;
    logic signed [ACC_W-1:0] acc_i [4];
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] snap_i [4];
    logic signed [ACC_W-1:0] snap_q [4];
    logic [E_W-1:0] energy [4];
    logic snap_vld;
    logic e_vld;

    logic restart;
    logic accept;
    logic last;
    logic [NW-1:0] n_eff;
    logic signed [ACC_W-1:0] xi;
    logic signed [ACC_W-1:0] xq;
    logic [3:0] lut_idx [4];
    logic signed [COEF_W-1:0] cos_v [4];
    logic signed [COEF_W-1:0] sin_v [4];
    logic signed [ACC_W-1:0] cx [4];
    logic signed [ACC_W-1:0] sx [4];
    logic signed [ACC_W-1:0] sum_i [4];
    logic signed [ACC_W-1:0] sum_q [4];
    logic signed [E_W-1:0] wi [4];
    logic signed [E_W-1:0] wq [4];
    logic [E_W-1:0] energy_next [4];
    logic [1:0] best_idx;
    logic [E_W-1:0] best_e;

    // A sync sample always restarts the symbol at n=0 on an empty
    // accumulator; at n=0 that is indistinguishable from normal flow.
    assign restart = in_valid && sym_sync;
    assign accept  = in_valid && ((state == ST_ACCUM) || sym_sync);
    assign n_eff   = restart ? '0 : n;
    assign last    = (n_eff == NW'(SPS - 1));
    assign xi      = ACC_W'(input_1);
    assign xq      = ACC_W'(input_2);

    for (genvar m = 0; m < 4; m++) begin : g_tone
        assign lut_idx[m] = coef_index(K_ARR[m], int'(n_eff), SPS);
        assign cx[m]      = ACC_W'(cos_v[m]);
        assign sx[m]      = ACC_W'(sin_v[m]);

        fsk4_tone_lut u_lut (
            .idx     (lut_idx[m]),
            .cos_val (cos_v[m]),
            .sin_val (sin_v[m])
        );
    end

    // (I + jQ) * (cos - j sin), added onto the running sums.
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            sum_i[m] = (restart ? ACC_ZERO : acc_i[m]) + xi * cx[m] + xq * sx[m];
            sum_q[m] = (restart ? ACC_ZERO : acc_q[m]) + xq * cx[m] - xi * sx[m];
        end
    end

    always_comb begin
        for (int m = 0; m < 4; m++) begin
            wi[m] = E_W'(snap_i[m] >>> SHIFT);
            wq[m] = E_W'(snap_q[m] >>> SHIFT);
            energy_next[m] = $unsigned(wi[m] * wi[m] + wq[m] * wq[m]);
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = 2'd0;
        best_e   = energy[0];
        for (int m = 1; m < 4; m++) begin
            if (energy[m] > best_e) begin
                best_e   = energy[m];
                best_idx = 2'(m);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n         <= '0;
            snap_vld  <= 1'b0;
            e_vld     <= 1'b0;
            sym_valid <= 1'b0;
            sym_out   <= '0;
            metric    <= '0;
            for (int m = 0; m < 4; m++) begin
                acc_i[m]  <= '0;
                acc_q[m]  <= '0;
                snap_i[m] <= '0;
                snap_q[m] <= '0;
                energy[m] <= '0;
            end
        end else begin
            snap_vld <= 1'b0;
            if (accept) begin
                state <= ST_ACCUM;
                if (last) begin
                    n        <= '0;
                    snap_vld <= 1'b1;
                    for (int m = 0; m < 4; m++) begin
                        snap_i[m] <= sum_i[m];
                        snap_q[m] <= sum_q[m];
                        acc_i[m]  <= '0;
                        acc_q[m]  <= '0;
                    end
                end else begin
                    n <= n_eff + 1'b1;
                    for (int m = 0; m < 4; m++) begin
                        acc_i[m] <= sum_i[m];
                        acc_q[m] <= sum_q[m];
                    end
                end
            end

            e_vld <= snap_vld;
            if (snap_vld) begin
                for (int m = 0; m < 4; m++) begin
                    energy[m] <= energy_next[m];
                end
            end

            sym_valid <= e_vld;
            if (e_vld) begin
                sym_out <= best_idx;
                metric  <= best_e;
            end
        end
    end

endmodule

// File: tb/tb_fsk4_tone_detector.sv
// tb_fsk4_tone_detector: directed and randomized checks of fsk4_tone_detector
// against a sample-list DFT model with a cycle-stamped expectation queue.
module tb_fsk4_tone_detector;

    localparam real PI = 3.14159265358979;
    localparam int KB [4] = '{1, 3, 5, 7};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic sym_sync = 1'b0;
    logic signed [17:0] input_1 = '0;
    logic signed [17:0] input_2 = '0;
    logic [1:0] sym_out;
    logic sym_valid;
    logic [47:0] metric;

    fsk4_tone_detector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .input_1   (input_1),
        .input_2   (input_2),
        .sym_sync  (sym_sync),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .metric    (metric)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int     cyc;
        int     sym;
        longint met;
    } exp_t;

    exp_t   exq[$];
    int     plog_cyc[$];
    int     plog_sym[$];
    longint plog_met[$];

    longint cos_t [16];
    longint sin_t [16];
    bit     m_active = 1'b0;
    int     m_n = 0;
    longint s_i [16];
    longint s_q [16];

    bit     chk_en = 1'b0;
    bit     rst_edge = 1'b1;
    int     held_sym = 0;
    longint held_met = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Direct 16-point correlation of the stored symbol against each bin.
    function automatic void decide(output int sym, output longint met);
        longint ai, aq, hi, hq, e;
        sym = 0;
        met = 0;
        for (int m = 0; m < 4; m++) begin
            ai = 0;
            aq = 0;
            for (int k = 0; k < 16; k++) begin
                int p;
                p = (KB[m] * k) % 16;
                ai += s_i[k] * cos_t[p] + s_q[k] * sin_t[p];
                aq += s_q[k] * cos_t[p] - s_i[k] * sin_t[p];
            end
            hi = ai >>> 16;
            hq = aq >>> 16;
            e  = hi * hi + hq * hq;
            if (m == 0 || e > met) begin
                met = e;
                sym = m;
            end
        end
    endfunction

    function automatic void model_sample(input bit sync, input longint i, input longint q);
        int     sym;
        longint met;
        if (sync) begin
            m_active = 1'b1;
            m_n = 0;
        end
        if (m_active) begin
            s_i[m_n] = i;
            s_q[m_n] = q;
            m_n++;
            if (m_n == 16) begin
                decide(sym, met);
                exq.push_back('{cyc + 3, sym, met});
                m_n = 0;
            end
        end
    endfunction

    function automatic int tone(input int k, input int n, input real a, input bit is_q);
        real x;
        if (is_q) x = a * $sin(2.0 * PI * k * n / 16.0);
        else      x = a * $cos(2.0 * PI * k * n / 16.0);
        return $rtoi($floor(x + 0.5));
    endfunction

    task automatic drive(input bit v, input bit sync, input int i, input int q);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = v;
        sym_sync = sync;
        input_1  = 18'(i);
        input_2  = 18'(q);
        if (v) model_sample(sync, i, q);
    endtask

    // Idle cycles carry junk data and sync that must be ignored.
    task automatic idle(input int cnt);
        for (int j = 0; j < cnt; j++)
            drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4000)) - 2000,
                  int'($urandom_range(0, 4000)) - 2000);
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sym_sync = 1'b0;
        while (exq.size() > 0 && exq[exq.size() - 1].cyc > cyc) void'(exq.pop_back());
        m_active = 1'b0;
        m_n      = 0;
    endtask

    task automatic send_symbol(input int k, input real amp, input int noise, input bit sync_first,
                               input int gap_mode, input int nsamp, output int last_cyc);
        int i, q;
        last_cyc = cyc;
        for (int n = 0; n < nsamp; n++) begin
            if (gap_mode == 1 && n > 0) idle(1);
            if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            i = tone(k, n, amp, 1'b0);
            q = tone(k, n, amp, 1'b1);
            if (noise > 0) begin
                i += int'($urandom_range(0, 2 * noise)) - noise;
                q += int'($urandom_range(0, 2 * noise)) - noise;
            end
            drive(1'b1, sync_first && (n == 0), i, q);
            last_cyc = cyc;
        end
    endtask

    always @(posedge clk) rst_edge <= rst;

    always @(negedge clk) begin
        if (chk_en) begin
            bit want;
            if (rst_edge) begin
                held_sym = 0;
                held_met = 0;
            end
            while (exq.size() > 0 && exq[0].cyc < cyc) void'(exq.pop_front());
            want = (exq.size() > 0) && (exq[0].cyc == cyc);
            chk("sym_valid", longint'(sym_valid), longint'(want));
            if (want) begin
                held_sym = exq[0].sym;
                held_met = exq[0].met;
                void'(exq.pop_front());
            end
            chk("sym_out", longint'(sym_out), longint'(held_sym));
            chk("metric", longint'(metric), held_met);
            if (sym_valid) begin
                plog_cyc.push_back(cyc);
                plog_sym.push_back(int'(sym_out));
                plog_met.push_back(longint'(metric));
            end
        end
    end

    initial begin
        int lc, p0, sym;
        longint met;

        for (int k = 0; k < 16; k++) begin
            cos_t[k] = longint'($rtoi($floor(16384.0 * $cos(2.0 * PI * k / 16.0) + 0.5)));
            sin_t[k] = longint'($rtoi($floor(16384.0 * $sin(2.0 * PI * k / 16.0) + 0.5)));
        end

        // Pin the model itself with hand-known answers.
        chk("model_cos0", cos_t[0], 16384);
        chk("model_sin2", sin_t[2], 11585);
        for (int n = 0; n < 16; n++) begin
            s_i[n] = tone(3, n, 20000.0, 1'b0);
            s_q[n] = tone(3, n, 20000.0, 1'b1);
        end
        decide(sym, met);
        chk("model_bin3_sym", sym, 1);
        for (int n = 0; n < 16; n++) begin
            s_i[n] = 0;
            s_q[n] = 0;
        end
        decide(sym, met);
        chk("model_zero_sym", sym, 0);
        chk("model_zero_metric", met, 0);

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_sym_valid", longint'(sym_valid), 0);
        chk("reset_sym_out", longint'(sym_out), 0);
        chk("reset_metric", longint'(metric), 0);

        // Single bin-3 symbol, pulse exactly three cycles after last sample.
        idle(2);
        p0 = plog_sym.size();
        send_symbol(3, 20000.0, 0, 1'b1, 0, 16, lc);
        idle(6);
        chk("t028_pulses", plog_sym.size() - p0, 1);
        if (plog_sym.size() > p0) begin
            chk("t028_sym", plog_sym[p0], 1);
            chk("t028_latency", plog_cyc[p0] - lc, 3);
        end

        // Four back-to-back symbols, sync re-asserted at each n=0.
        p0 = plog_sym.size();
        for (int b = 0; b < 4; b++) send_symbol(KB[b], 30000.0, 0, 1'b1, 0, 16, lc);
        idle(6);
        chk("t029_pulses", plog_sym.size() - p0, 4);
        if (plog_sym.size() >= p0 + 4) begin
            for (int b = 0; b < 4; b++) chk("t029_sym", plog_sym[p0 + b], b);
            for (int b = 1; b < 4; b++) chk("t029_spacing", plog_cyc[p0 + b] - plog_cyc[p0 + b - 1], 16);
        end

        // All-zero symbol resolves to tone 0 with zero energy.
        p0 = plog_sym.size();
        send_symbol(0, 0.0, 0, 1'b1, 0, 16, lc);
        idle(6);
        chk("t030_pulses", plog_sym.size() - p0, 1);
        if (plog_sym.size() > p0) begin
            chk("t030_sym", plog_sym[p0], 0);
            chk("t030_metric", plog_met[p0], 0);
        end

        // Resync at n=7 drops the partial symbol.
        p0 = plog_sym.size();
        send_symbol(7, 30000.0, 0, 1'b1, 0, 7, lc);
        send_symbol(5, 30000.0, 0, 1'b1, 0, 16, lc);
        idle(6);
        chk("t031_pulses", plog_sym.size() - p0, 1);
        if (plog_sym.size() > p0) begin
            chk("t031_sym", plog_sym[p0], 2);
            chk("t031_latency", plog_cyc[p0] - lc, 3);
        end

        // Bin 5 gapless versus in_valid low every other cycle.
        p0 = plog_sym.size();
        send_symbol(5, 25000.0, 0, 1'b1, 0, 16, lc);
        idle(6);
        send_symbol(5, 25000.0, 0, 1'b1, 1, 16, lc);
        idle(6);
        chk("t032_pulses", plog_sym.size() - p0, 2);
        if (plog_sym.size() >= p0 + 2) begin
            chk("t032_sym_gapless", plog_sym[p0], 2);
            chk("t032_sym_gapped", plog_sym[p0 + 1], 2);
            chk("t032_metric_equal", plog_met[p0 + 1], plog_met[p0]);
            chk("t032_latency", plog_cyc[p0 + 1] - lc, 3);
        end

        // Reset at n=15, then one cycle after a complete symbol, then no sync.
        p0 = plog_sym.size();
        send_symbol(1, 30000.0, 0, 1'b1, 0, 15, lc);
        reset_cycle();
        idle(3);
        send_symbol(1, 30000.0, 0, 1'b1, 0, 16, lc);
        reset_cycle();
        idle(3);
        send_symbol(1, 30000.0, 0, 1'b0, 0, 16, lc);
        idle(6);
        chk("t033_pulses", plog_sym.size() - p0, 0);
        @(negedge clk);
        chk("t033_sym_out", longint'(sym_out), 0);
        chk("t033_metric", longint'(metric), 0);

        // Randomized traffic: noise, gaps, truncated symbols, stray resets.
        for (int r = 0; r < 40; r++) begin
            int nsamp;
            nsamp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
            send_symbol(int'($urandom_range(0, 7)), real'($urandom_range(3000, 60000)),
                        int'($urandom_range(0, 3000)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 2)), nsamp, lc);
            if ($urandom_range(0, 15) == 0) reset_cycle();
            idle(int'($urandom_range(0, 3)));
        end
        idle(8);
        chk("scoreboard_drained", exq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
